// File: rtl/enc16to4_seq_if.sv
// Handshake/bus bundle for the sequential 16-to-4 priority encoder.
// Producer side: req_in/req_valid fill the pending set. Consumer side: out_valid/out_ready transfer out_code.
interface enc16to4_seq_if;
  logic [15:0] req_in;
  logic        req_valid;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_code;
  logic [15:0] pend;
  logic [4:0]  pend_cnt;
  logic        ovf;
  logic        state;     // debug view: 0 = IDLE (nothing pending), 1 = ACTIVE

  modport master (
    output req_in, req_valid, out_ready,
    input  out_valid, out_code, pend, pend_cnt, ovf, state
  );

  modport slave (
    input  req_in, req_valid, out_ready,
    output out_valid, out_code, pend, pend_cnt, ovf, state
  );
endinterface

// File: rtl/enc16to4_seq.sv
// Sequential 16-to-4 priority encoder: accumulates requests and serves one code per handshake.
// Optional sticky lost-event flag enabled by defining ENC_OVERFLOW_EN.
module enc16to4_seq #(
  parameter int PRIO_HIGH = 1
) (
  input  logic          clk,
  input  logic          rst,
  enc16to4_seq_if.slave bus
);

  // Valid/ready: a code transfers in any cycle where out_valid & out_ready are both 1;
  // out_ready is ignored while out_valid=0, and a pending bit is only cleared by a transfer.

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [15:0] pend_q;
  logic        valid_q;
  logic [3:0]  code_q;
  logic [4:0]  cnt_q;
  state_t      state_q;

  logic [15:0] clr;
  logic [15:0] pend_nxt;
  logic [3:0]  code_nxt;
  logic [4:0]  cnt_nxt;

  function automatic logic [3:0] prio_encode(input logic [15:0] v);
    logic [3:0] c;
    c = 4'd0;
    // Scan toward the winning end so the last hit is the highest-priority bit.
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < 16; i++)
        if (v[i]) c = i[3:0];
    end else begin
      for (int i = 15; i >= 0; i--)
        if (v[i]) c = i[3:0];
    end
    return c;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++)
      n = n + {4'd0, v[i]};
    return n;
  endfunction

  always_comb begin
    clr      = 16'h0;
    if (valid_q && bus.out_ready)
      clr = 16'h1 << code_q;
    // A new request is ORed in after the clear, so re-requesting a served bit keeps it pending.
    pend_nxt = (pend_q & ~clr) | (bus.req_valid ? bus.req_in : 16'h0);
    code_nxt = prio_encode(pend_nxt);
    cnt_nxt  = popcount(pend_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 16'h0;
      valid_q <= 1'b0;
      code_q  <= 4'd0;
      cnt_q   <= 5'd0;
      state_q <= IDLE;
    end else begin
      pend_q  <= pend_nxt;
      valid_q <= |pend_nxt;
      code_q  <= code_nxt;
      cnt_q   <= cnt_nxt;
      state_q <= (|pend_nxt) ? ACTIVE : IDLE;
    end
  end

`ifdef ENC_OVERFLOW_EN
  logic ovf_q;
  logic lost;

  // A request for a bit that is pending and not served this cycle is a dropped event.
  assign lost = bus.req_valid && (|(bus.req_in & pend_q & ~clr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (lost)
      ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.pend      = pend_q;
  assign bus.out_valid = valid_q;
  assign bus.out_code  = code_q;
  assign bus.pend_cnt  = cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_enc16to4_seq.sv
// Bench for enc16to4_seq: one instance per priority order, driven with identical stimulus.
module tb_enc16to4_seq;

  logic clk;
  logic rst;

  enc16to4_seq_if bus_h ();
  enc16to4_seq_if bus_l ();

  enc16to4_seq #(.PRIO_HIGH(1)) dut_h (.clk(clk), .rst(rst), .bus(bus_h.slave));
  enc16to4_seq #(.PRIO_HIGH(0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

  int checks   = 0;
  int failures = 0;

`ifdef ENC_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  typedef struct {
    logic [15:0] req_in;
    logic        req_valid;
    logic        out_ready;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic [15:0] exp_pend;
    logic [4:0]  exp_cnt;
    logic [3:0]  exp_code_lo;
  } vec_t;

  vec_t vecs[16];

  logic [3:0] exp_q[$];
  logic [3:0] exp_lo_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] req, input logic rv, input logic rdy);
    bus_h.req_in    = req;
    bus_h.req_valid = rv;
    bus_h.out_ready = rdy;
    bus_l.req_in    = req;
    bus_l.req_valid = rv;
    bus_l.out_ready = rdy;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " pend"},      {16'h0, bus_h.pend},     32'h0);
    check({tag, " out_valid"}, {31'h0, bus_h.out_valid}, 32'h0);
    check({tag, " out_code"},  {28'h0, bus_h.out_code}, 32'h0);
    check({tag, " pend_cnt"},  {27'h0, bus_h.pend_cnt}, 32'h0);
    check({tag, " state"},     {31'h0, bus_h.state},    32'h0);
  endtask

  initial begin
    // single, priority drain, backpressure/preempt, simultaneous clear+set, zero request
    vecs[0]  = '{16'h0020, 1'b1, 1'b1, 1'b1, 4'd5,  16'h0020, 5'd1, 4'd5};
    vecs[1]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 5'd0, 4'd0};
    vecs[2]  = '{16'h8421, 1'b1, 1'b1, 1'b1, 4'd15, 16'h8421, 5'd4, 4'd0};
    vecs[3]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 4'd10, 16'h0421, 5'd3, 4'd5};
    vecs[4]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 4'd5,  16'h0021, 5'd2, 4'd10};
    vecs[5]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 4'd0,  16'h0001, 5'd1, 4'd15};
    vecs[6]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 5'd0, 4'd0};
    vecs[7]  = '{16'h0010, 1'b1, 1'b0, 1'b1, 4'd4,  16'h0010, 5'd1, 4'd4};
    vecs[8]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'd4,  16'h0010, 5'd1, 4'd4};
    vecs[9]  = '{16'h0100, 1'b1, 1'b0, 1'b1, 4'd8,  16'h0110, 5'd2, 4'd4};
    vecs[10] = '{16'h0000, 1'b0, 1'b1, 1'b1, 4'd4,  16'h0010, 5'd1, 4'd8};
    vecs[11] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 5'd0, 4'd0};
    vecs[12] = '{16'h0008, 1'b1, 1'b1, 1'b1, 4'd3,  16'h0008, 5'd1, 4'd3};
    vecs[13] = '{16'h0008, 1'b1, 1'b1, 1'b1, 4'd3,  16'h0008, 5'd1, 4'd3};
    vecs[14] = '{16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 5'd0, 4'd0};
    vecs[15] = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 5'd0, 4'd0};

    rst = 1'b1;
    drive(16'h0, 1'b0, 1'b0);
    step();
    step();
    check_idle("reset");
    check("reset ovf", {31'h0, bus_h.ovf}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].req_in, vecs[i].req_valid, vecs[i].out_ready);
      step();
      check($sformatf("vec%0d out_valid", i), {31'h0, bus_h.out_valid}, {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d out_code", i),  {28'h0, bus_h.out_code},  {28'h0, vecs[i].exp_code});
      check($sformatf("vec%0d pend", i),      {16'h0, bus_h.pend},      {16'h0, vecs[i].exp_pend});
      check($sformatf("vec%0d pend_cnt", i),  {27'h0, bus_h.pend_cnt},  {27'h0, vecs[i].exp_cnt});
      check($sformatf("vec%0d code_lo", i),   {28'h0, bus_l.out_code},  {28'h0, vecs[i].exp_code_lo});
    end
    check("table ovf", {31'h0, bus_h.ovf}, 32'h0);

    // asynchronous reset mid-stream, checked before any clock edge
    drive(16'h00F0, 1'b1, 1'b0);
    step();
    check("pre-rst pend", {16'h0, bus_h.pend}, 32'h00F0);
    drive(16'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_idle("async rst");
    #1 rst = 1'b0;
    step();
    check_idle("post rst");

    // full load, lost event, full drain in both priority orders
    drive(16'hFFFF, 1'b1, 1'b0);
    step();
    check("full pend",     {16'h0, bus_h.pend},     32'hFFFF);
    check("full pend_cnt", {27'h0, bus_h.pend_cnt}, 32'd16);
    check("full code_hi",  {28'h0, bus_h.out_code}, 32'd15);
    check("full code_lo",  {28'h0, bus_l.out_code}, 32'd0);
    check("full ovf",      {31'h0, bus_h.ovf},      32'h0);
    drive(16'h0001, 1'b1, 1'b0);
    step();
    check("rereq ovf",    {31'h0, bus_h.ovf},      {31'h0, EXP_OVF});
    check("rereq pend",   {16'h0, bus_h.pend},     32'hFFFF);
    check("rereq ovf_lo", {31'h0, bus_l.ovf},      {31'h0, EXP_OVF});
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(4'(15 - i));
      exp_lo_q.push_back(4'(i));
    end
    drive(16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] e_h;
      logic [3:0] e_l;
      e_h = exp_q.pop_front();
      e_l = exp_lo_q.pop_front();
      check($sformatf("drain%0d valid", i), {31'h0, bus_h.out_valid}, 32'h1);
      check($sformatf("drain%0d code_hi", i), {28'h0, bus_h.out_code}, {28'h0, e_h});
      check($sformatf("drain%0d code_lo", i), {28'h0, bus_l.out_code}, {28'h0, e_l});
      check($sformatf("drain%0d pend_cnt", i), {27'h0, bus_h.pend_cnt}, 32'(16 - i));
      step();
    end
    check_idle("drained");
    check("sticky ovf", {31'h0, bus_h.ovf}, {31'h0, EXP_OVF});
    rst = 1'b1;
    #1;
    check("rst clears ovf", {31'h0, bus_h.ovf}, 32'h0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
